// File: rtl/fp_pkg.sv
// Shared types, constants and operand unpack helper for the FP32 add/subtract unit.
package fp_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXT_W    = 27;
    localparam int unsigned EXP_BIAS = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound} state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [EXT_W-1:0] ext;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_unpacked_t;

    // Denormals flush to signed zero; ext carries hidden bit plus guard/round/sticky slots.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:MAN_W];
        u.is_zero = (u.exp == '0);
        u.is_inf  = (u.exp == '1) && (x[MAN_W-1:0] == '0);
        u.is_nan  = (u.exp == '1) && (x[MAN_W-1:0] != '0);
        u.ext     = u.is_zero ? '0 : {1'b1, x[MAN_W-1:0], 3'b000};
        return u;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational 28-bit leading-zero counter; all-zero input yields 28.
module fp_lzc (
    input  logic [27:0] din,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (din[i]) count = 5'(27 - i);
        end
    end

endmodule

// File: rtl/fp_add_exec.sv
// Multi-cycle FP32 add/subtract execute unit: IDLE -> ALIGN -> ADD -> NORM -> ROUND.
// Define FP_ADD_EXCEPT_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} port.
module fp_add_exec
    import fp_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic [31:0]           op_a,
    input  logic [31:0]           op_b,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  out_valid,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [31:0]           result
`ifdef FP_ADD_EXCEPT_FLAGS_EN
   ,output logic [3:0]            flags
`endif
);

    state_e                state;
    logic [31:0]           a_q, b_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  sign_q, eff_sub_q, sum_zero_q;
    logic [9:0]            exp_q, norm_exp_q;
    logic [26:0]           big_man_q, small_man_q, norm_man_q;
    logic [27:0]           sum_q;

    fp_unpacked_t ua, ub;
    assign ua = fp_unpack(a_q);
    assign ub = fp_unpack(b_q);
    assign in_ready = (state == StIdle);

    // ALIGN: order by magnitude, then shift the smaller operand with sticky collection
    logic                  swap, big_sign, small_sign;
    logic [EXP_W-1:0]      big_exp, small_exp, exp_diff;
    logic [EXT_W-1:0]      big_ext, small_ext, align_man;
    logic [4:0]            shamt;
    logic [2*EXT_W-1:0]    shifted;

    always_comb begin
        swap       = {ub.exp, ub.ext} > {ua.exp, ua.ext};
        big_sign   = swap ? ub.sign : ua.sign;
        small_sign = swap ? ua.sign : ub.sign;
        big_exp    = swap ? ub.exp  : ua.exp;
        small_exp  = swap ? ua.exp  : ub.exp;
        big_ext    = swap ? ub.ext  : ua.ext;
        small_ext  = swap ? ua.ext  : ub.ext;
        exp_diff   = big_exp - small_exp;
        shamt      = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        shifted    = {small_ext, 27'b0} >> shamt;
        align_man  = {shifted[53:28], shifted[27] | (|shifted[26:0])};
    end

    logic [27:0] sum_d;
    assign sum_d = eff_sub_q ? ({1'b0, big_man_q} - {1'b0, small_man_q})
                             : ({1'b0, big_man_q} + {1'b0, small_man_q});

    // NORM: left shift is capped so the exponent never drops below 1
    logic [4:0]  lz;
    logic [9:0]  lz27, max_sh, sh, norm_exp_d;
    logic [26:0] norm_man_d;

    fp_lzc u_lzc (
        .din   (sum_q),
        .count (lz)
    );

    always_comb begin
        lz27   = {5'b0, lz} - 10'd1;
        max_sh = (exp_q == 10'd0) ? 10'd0 : exp_q - 10'd1;
        sh     = (lz27 < max_sh) ? lz27 : max_sh;
        if (sum_q[27]) begin
            norm_man_d = {sum_q[27:2], |sum_q[1:0]};
            norm_exp_d = exp_q + 10'd1;
        end else begin
            norm_man_d = sum_q[26:0] << sh;
            norm_exp_d = exp_q - sh;
        end
    end

    // ROUND: nearest-even, then special-case resolution
    logic        rnd_up, is_invalid, is_special;
    logic [24:0] rnd;
    logic [23:0] mant;
    logic [9:0]  rexp;
    logic [31:0] res_d;

    always_comb begin
        rnd_up = norm_man_q[2] & (norm_man_q[1] | norm_man_q[0] | norm_man_q[3]);
        rnd    = {1'b0, norm_man_q[26:3]} + {24'b0, rnd_up};
        if (rnd[24]) begin
            mant = rnd[24:1];
            rexp = norm_exp_q + 10'd1;
        end else begin
            mant = rnd[23:0];
            rexp = norm_exp_q;
        end
        is_invalid = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & (ua.sign ^ ub.sign));
        is_special = is_invalid | ua.is_inf | ub.is_inf;

        res_d = {sign_q, rexp[7:0], mant[22:0]};
        if (is_invalid)           res_d = QNAN;
        else if (ua.is_inf)       res_d = ua.sign ? NEG_INF : POS_INF;
        else if (ub.is_inf)       res_d = ub.sign ? NEG_INF : POS_INF;
        else if (sum_zero_q)      res_d = {ua.is_zero & ub.is_zero & ua.sign & ub.sign, 31'b0};
        else if (rexp >= 10'd255) res_d = sign_q ? NEG_INF : POS_INF;
        else if (!mant[23])       res_d = {sign_q, 31'b0};
    end

`ifdef FP_ADD_EXCEPT_FLAGS_EN
    logic       f_ovf, f_unf, f_inx;
    logic [3:0] flags_d;

    always_comb begin
        f_ovf   = !is_special && !sum_zero_q && (rexp >= 10'd255);
        f_unf   = !is_special && !sum_zero_q && (rexp < 10'd255) && !mant[23];
        f_inx   = !is_special && ((|norm_man_q[2:0]) | f_ovf | f_unf);
        flags_d = {is_invalid, f_ovf, f_unf, f_inx};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            out_valid   <= 1'b0;
            result      <= '0;
            rd_out      <= '0;
`ifdef FP_ADD_EXCEPT_FLAGS_EN
            flags       <= '0;
`endif
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            sum_zero_q  <= 1'b0;
            exp_q       <= '0;
            norm_exp_q  <= '0;
            big_man_q   <= '0;
            small_man_q <= '0;
            norm_man_q  <= '0;
            sum_q       <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= op_a;
                        b_q   <= {op_b[31] ^ op_sub, op_b[30:0]};
                        rd_q  <= rd_in;
                        state <= StAlign;
                    end
                end
                StAlign: begin
                    sign_q      <= big_sign;
                    eff_sub_q   <= big_sign ^ small_sign;
                    exp_q       <= {2'b0, big_exp};
                    big_man_q   <= big_ext;
                    small_man_q <= align_man;
                    state       <= StAdd;
                end
                StAdd: begin
                    sum_q <= sum_d;
                    state <= StNorm;
                end
                StNorm: begin
                    norm_man_q <= norm_man_d;
                    norm_exp_q <= norm_exp_d;
                    sum_zero_q <= (sum_q == '0);
                    state      <= StRound;
                end
                StRound: begin
                    result    <= res_d;
                    rd_out    <= rd_q;
                    out_valid <= 1'b1;
`ifdef FP_ADD_EXCEPT_FLAGS_EN
                    flags     <= flags_d;
`endif
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_exec.sv
// Scoreboard bench for fp_add_exec: expected results queued at issue, compared on out_valid.
module tb_fp_add_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic [4:0]  rd_out;
    logic [31:0] result;
`ifdef FP_ADD_EXCEPT_FLAGS_EN
    logic [3:0]  flags;
`endif

    fp_add_exec #(.REG_ADDR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .rd_out    (rd_out),
        .result    (result)
`ifdef FP_ADD_EXCEPT_FLAGS_EN
       ,.flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [3:0]  flg;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", result, e.res);
                check_eq("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
                check_eq("latency", 32'(cyc), e.cyc);
`ifdef FP_ADD_EXCEPT_FLAGS_EN
                check_eq("flags", {28'b0, flags}, {28'b0, e.flg});
`endif
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [4:0] rd, input logic [31:0] er, input logic [3:0] ef);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        rd_in    = rd;
        @(posedge clk);
        #1;
        sb.push_back('{res: er, rd: rd, flg: ef, cyc: 32'(cyc + 4)});
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    // flags = {invalid, overflow, underflow, inexact}
    vec_t vecs[] = '{
        '{32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 4'b0000},
        '{32'h40000000, 32'h00000000, 1'b0, 32'h40000000, 4'b0000},
        '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000},
        '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},
        '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},
        '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000},
        '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'b0000},
        '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000},
        '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000},
        '{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},
        '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000},
        '{32'hC0000000, 32'h40400000, 1'b1, 32'hC0A00000, 4'b0000},
        '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011},
        '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'b0000}
    };

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op_sub   = 1'b0;
        op_a     = '0;
        op_b     = '0;
        rd_in    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_rd_out", {27'b0, rd_out}, 32'd0);
        rst_n = 1'b1;

        // Operation vectors; rd rotates so each result is tagged distinctly
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, 5'(i + 3), vecs[i].res, vecs[i].flg);
            drain();
        end

        // Back-to-back with in_valid held and operands churning while busy
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 32'h3F800000;
        op_b     = 32'h3F800000;
        op_sub   = 1'b0;
        rd_in    = 5'd7;
        @(posedge clk);
        #1;
        e0 = cyc;
        sb.push_back('{res: 32'h40000000, rd: 5'd7, flg: 4'b0000, cyc: 32'(e0 + 4)});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("busy_in_ready", 32'(in_ready), 32'd0);
            if (k == 0) begin
                op_a   = 32'h12345678;
                op_b   = 32'hDEADBEEF;
                op_sub = 1'b1;
                rd_in  = 5'd30;
            end else if (k == 1) begin
                op_a   = 32'h40400000;
                op_b   = 32'h40000000;
                op_sub = 1'b1;
                rd_in  = 5'd9;
            end
        end
        @(negedge clk);
        check_eq("done_in_ready", 32'(in_ready), 32'd1);
        check_eq("done_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        sb.push_back('{res: 32'h3F800000, rd: 5'd9, flg: 4'b0000, cyc: 32'(e0 + 9)});
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("second_busy", 32'(in_ready), 32'd0);
        drain();

        // Reset while in NORM: operation discarded, no completion strobe
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 32'h40000000;
        op_b     = 32'h40400000;
        op_sub   = 1'b0;
        rd_in    = 5'd21;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("post_rst_result", result, 32'd0);
        check_eq("post_rst_rd_out", {27'b0, rd_out}, 32'd0);
        repeat (6) @(negedge clk);

        issue(32'h40000000, 32'h40400000, 1'b0, 5'd3, 32'h40A00000, 4'b0000);
        drain();
        repeat (3) @(negedge clk);
        check_eq("hold_result", result, 32'h40A00000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
